mont_modmul: RTL and testbench

MONT_MODMUL -- requirements
Module: mont_modmul

---
 rtl/mont_modmul.sv | 176 +++++++++++++++++
 tb/tb_mont_modmul.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mont_modmul.sv
// -----------------------------------------------------------------------------
// mont_modmul -- radix-2 interleaved Montgomery modular multiplier
//
// Computes result = x * y * 2^-WIDTH mod n, one bit of x per clock, LSB first.
// A start in IDLE captures the operands, WIDTH ITER cycles build the
// Montgomery accumulator, and one SUB cycle brings it below n and raises
// done for a single cycle.
//
// Parameters
//   WIDTH      operand / modulus width in bits (4..4096)
//
// Ports
//   clk        rising-edge clock for all state
//   sys_rst_n  asynchronous, active-low reset
//   start      request pulse, sampled only in IDLE
//   x, y       multiplicand / multiplier (both expected < n)
//   n          modulus (expected odd and > 1)
//   busy       high while an operation is in flight
//   done       one-cycle pulse, result and err valid in that cycle
//   result     Montgomery product, held until the next done
//   err        even-modulus flag, valid with done
//
// Build option
//   MONT_ODD_CHECK_EN  when defined, an even n bypasses ITER, finishes after
//                      two cycles with result=0 and err=1; when undefined err
//                      is tied low and an even n is processed normally.
// -----------------------------------------------------------------------------
module mont_modmul #(
   parameter int WIDTH = 2048
) (
   input  logic             clk,
   input  logic             sys_rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] n,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   // Two guard bits keep A + y + n from overflowing while A < 2n.
   localparam int AW = WIDTH + 2;
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      SUB  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [WIDTH-1:0]  r_x;        // shifts right so bit 0 is the current x bit
   logic [WIDTH-1:0]  r_y;
   logic [WIDTH-1:0]  r_n;
   logic [AW-1:0]     r_a;
   logic [CW-1:0]     r_cnt;
   logic              r_even;     // modulus was rejected at start
   logic              r_done;
   logic [WIDTH-1:0]  r_result;

   logic              w_even_n;
   logic              w_last;
   logic [AW-1:0]     w_add_y;
   logic [AW-1:0]     w_sum1;
   logic [AW-1:0]     w_add_n;
   logic [AW-1:0]     w_a_nxt;
   logic              w_ge_n;
   logic [WIDTH-1:0]  w_red;

`ifdef MONT_ODD_CHECK_EN
   logic              r_err;
   assign w_even_n = ~n[0];
`else
   assign w_even_n = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Iteration datapath: A = (A + x[i]*y + q*n) / 2, q chosen to make it even
   // ---------------------------------------------------------------------------
   assign w_add_y = r_x[0]    ? {2'b00, r_y} : '0;
   assign w_sum1  = r_a + w_add_y;
   assign w_add_n = w_sum1[0] ? {2'b00, r_n} : '0;
   assign w_a_nxt = (w_sum1 + w_add_n) >> 1;

   // Final reduction. When A >= n the true difference is < n < 2^WIDTH, so
   // the low WIDTH bits of a WIDTH-bit subtraction are already exact.
   assign w_ge_n  = (r_a >= {2'b00, r_n});
   assign w_red   = w_ge_n ? (r_a[WIDTH-1:0] - r_n) : r_a[WIDTH-1:0];

   assign w_last  = (r_cnt == CW'(WIDTH - 1));

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   // NOTE: all clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) r_state <= IDLE;
      else            r_state <= w_state_nxt;
   end

   // ---------------------------------------------------------------------------
   // FSM next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: the default assignment up front guarantees no latch is inferred
   // for paths that do not change state.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: if (start) w_state_nxt = w_even_n ? SUB : ITER;
         ITER: if (w_last) w_state_nxt = SUB;
         SUB:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Operand, accumulator and result registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_x      <= '0;
         r_y      <= '0;
         r_n      <= '0;
         r_a      <= '0;
         r_cnt    <= '0;
         r_even   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_x    <= x;
                  r_y    <= y;
                  r_n    <= n;
                  r_a    <= '0;
                  r_cnt  <= '0;
                  r_even <= w_even_n;
               end
            end
            ITER: begin
               r_a   <= w_a_nxt;
               r_x   <= r_x >> 1;
               r_cnt <= r_cnt + CW'(1);
            end
            SUB: begin
               r_result <= r_even ? '0 : w_red;
               r_done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef MONT_ODD_CHECK_EN
   // err only moves in SUB, so it holds between done pulses like result.
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n)          r_err <= 1'b0;
      else if (r_state == SUB) r_err <= r_even;
   end
   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign busy   = (r_state != IDLE);
   assign done   = r_done;
   assign result = r_result;

endmodule

// File: tb/tb_mont_modmul.sv
// -----------------------------------------------------------------------------
// tb_mont_modmul -- directed self-checking bench for mont_modmul at WIDTH=8
//
// Latency is counted in falling edges after the start edge: the value seen at
// falling edge c is what rising edge c samples. done is expected at c=10
// (c=2 for a rejected even modulus). Expected results are x*y*3 mod 13 etc.,
// worked out by hand from 2^8 mod n.
// -----------------------------------------------------------------------------
module tb_mont_modmul;

   localparam int W = 8;

   logic          clk       = 1'b0;
   logic          sys_rst_n = 1'b0;
   logic          start     = 1'b0;
   logic [W-1:0]  x         = '0;
   logic [W-1:0]  y         = '0;
   logic [W-1:0]  n         = '0;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mont_modmul #(.WIDTH(W)) dut (
      .clk       (clk),
      .sys_rst_n (sys_rst_n),
      .start     (start),
      .x         (x),
      .y         (y),
      .n         (n),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .err       (err)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Present operands with start, let one rising edge take them, then
   // scramble the inputs to show the DUT works from its own copies.
   task automatic launch(input logic [W-1:0] xi, input logic [W-1:0] yi,
                         input logic [W-1:0] ni);
      x = xi; y = yi; n = ni; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      x = ~xi; y = ~yi; n = ~ni;
   endtask

   // Returns the falling-edge index of done (0 on timeout) and whether busy
   // stayed high before done and was low in the done cycle.
   task automatic wait_done(output int lat, output bit busy_ok);
      lat     = 0;
      busy_ok = 1'b1;
      for (int c = 1; c <= 64; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = c;
            if (busy !== 1'b0) busy_ok = 1'b0;
            return;
         end
         if (busy !== 1'b1) busy_ok = 1'b0;
      end
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] xi, input logic [W-1:0] yi,
                         input logic [W-1:0] ni, input logic [W-1:0] exp_res,
                         input int exp_lat, input logic exp_err);
      int lat;
      bit busy_ok;
      launch(xi, yi, ni);
      wait_done(lat, busy_ok);
      check({tag, "_lat"},  lat,     exp_lat);
      check({tag, "_res"},  result,  exp_res);
      check({tag, "_err"},  err,     exp_err);
      check({tag, "_busy"}, busy_ok, 1);
   endtask

   initial begin
      int       lat;
      bit       busy_ok;
      int       dones;
      int       first;
      logic [W-1:0] res_seen;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy",   busy,   0);
      check("rst_done",   done,   0);
      check("rst_result", result, 0);
      check("rst_err",    err,    0);
      sys_rst_n = 1'b1;
      @(negedge clk);

      // Basic product: 5*7*3 mod 13 = 1
      run_op("basic", 8'd5, 8'd7, 8'd13, 8'd1, 10, 1'b0);

      // Back-to-back: second start lands in the first op's done cycle
      run_op("b2b_a", 8'd12, 8'd12, 8'd13, 8'd3, 10, 1'b0);
      run_op("b2b_b", 8'd0,  8'd9,  8'd13, 8'd0, 10, 1'b0);

      // Top-bit operands and largest odd modulus
      run_op("p251", 8'd250, 8'd250, 8'd251, 8'd201, 10, 1'b0);
      repeat (4) @(negedge clk);
      check("hold_result", result, 201);
      check("hold_done",   done,   0);
      run_op("n255", 8'd254, 8'd1, 8'd255, 8'd254, 10, 1'b0);
      run_op("n3",   8'd1,   8'd1, 8'd3,   8'd1,   10, 1'b0);

      // start while busy must be ignored (restart with x=1 would give 8)
      launch(8'd5, 8'd7, 8'd13);
      dones    = 0;
      first    = 0;
      res_seen = '0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            dones++;
            if (first == 0) begin
               first    = c;
               res_seen = result;
            end
         end
         if (c == 4) begin
            x = 8'd1; y = 8'd7; n = 8'd13; start = 1'b1;
         end
         if (c == 5) start = 1'b0;
      end
      check("ign_dones", dones,    1);
      check("ign_lat",   first,    10);
      check("ign_res",   res_seen, 1);

      // Reset in mid-operation aborts with no done pulse
      launch(8'd5, 8'd7, 8'd13);
      repeat (5) @(negedge clk);
      sys_rst_n = 1'b0;
      #1;
      check("mid_rst_busy",   busy,   0);
      check("mid_rst_done",   done,   0);
      check("mid_rst_result", result, 0);
      repeat (2) @(negedge clk);
      sys_rst_n = 1'b1;
      dones = 0;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      check("mid_rst_nodone", dones, 0);
      run_op("post_rst", 8'd5, 8'd7, 8'd13, 8'd1, 10, 1'b0);

      // Even modulus
`ifdef MONT_ODD_CHECK_EN
      run_op("even", 8'd5, 8'd7, 8'd12, 8'd0, 2, 1'b1);
`else
      launch(8'd5, 8'd7, 8'd12);
      wait_done(lat, busy_ok);
      check("even_lat",  lat,     10);
      check("even_err",  err,     0);
      check("even_busy", busy_ok, 1);
`endif
      // err must drop again on the next good modulus
      run_op("after_even", 8'd1, 8'd1, 8'd13, 8'd3, 10, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
